// File: rtl/edf_selector.sv
// Earliest-deadline-first queue selector.
// Keeps one down-counting deadline per queue, picks the pending queue with the
// smallest deadline each cycle (lowest index on ties), and registers the
// choice as a valid/id grant strobe for the downstream dispatch stage.
// The queue granted in the current cycle is masked out of selection so a
// queue whose pop is still in flight is never granted twice back to back.
module edf_selector #(
    parameter int QUEUES         = 4,
    parameter int DEADLINE_WIDTH = 16,
    localparam int ID_WIDTH      = (QUEUES > 1) ? $clog2(QUEUES) : 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [QUEUES-1:0]                pending,
    input  logic [QUEUES*DEADLINE_WIDTH-1:0] period,
    input  logic                             miss_clear,
    output logic                             valid,
    output logic [ID_WIDTH-1:0]              id,
    output logic [QUEUES-1:0]                miss
);

    localparam logic [DEADLINE_WIDTH-1:0] DEC_ONE = DEADLINE_WIDTH'(1);

    logic [DEADLINE_WIDTH-1:0] deadline [QUEUES];
    logic [QUEUES-1:0]         granted;
    logic [QUEUES-1:0]         candidate;
    logic [QUEUES-1:0]         miss_set;
    logic                      sel_found;
    logic [ID_WIDTH-1:0]       sel_id;
    logic [DEADLINE_WIDTH-1:0] sel_deadline;

    // Decode the current grant, form the candidate mask and the miss conditions.
    always_comb begin
        granted   = '0;
        candidate = '0;
        miss_set  = '0;
        for (int unsigned i = 0; i < QUEUES; i++) begin
            granted[i]   = valid && (id == ID_WIDTH'(i));
            candidate[i] = pending[i] && !granted[i];
            miss_set[i]  = enable && pending[i] && (deadline[i] == '0) && !granted[i];
        end
    end

    // Minimum-deadline search; strict less-than keeps the lowest index on ties.
    always_comb begin
        sel_found    = 1'b0;
        sel_id       = '0;
        sel_deadline = '1;
        for (int unsigned i = 0; i < QUEUES; i++) begin
            if (candidate[i] && (!sel_found || (deadline[i] < sel_deadline))) begin
                sel_found    = 1'b1;
                sel_id       = ID_WIDTH'(i);
                sel_deadline = deadline[i];
            end
        end
    end

    // Registered grant strobe; id keeps its last value whenever nothing is granted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            id    <= '0;
        end else if (enable && sel_found) begin
            valid <= 1'b1;
            id    <= sel_id;
        end else begin
            valid <= 1'b0;
        end
    end

    // Deadline counters: reload on grant or idle, otherwise count down to zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < QUEUES; i++) begin
                deadline[i] <= '1;
            end
        end else if (enable) begin
            for (int unsigned i = 0; i < QUEUES; i++) begin
                if (granted[i] || !pending[i]) begin
                    deadline[i] <= period[i*DEADLINE_WIDTH +: DEADLINE_WIDTH];
                end else if (deadline[i] != '0) begin
                    deadline[i] <= deadline[i] - DEC_ONE;
                end
            end
        end
    end

    // Sticky miss flags; a new miss in the same cycle overrides the clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            miss <= '0;
        end else begin
            miss <= (miss & ~{QUEUES{miss_clear}}) | miss_set;
        end
    end

endmodule

// File: tb/tb_edf_selector.sv
// Directed self-checking bench for edf_selector (QUEUES=4, DEADLINE_WIDTH=8).
module tb_edf_selector;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [3:0]  pending;
    logic [31:0] period;
    logic        miss_clear;
    logic        valid;
    logic [1:0]  id;
    logic [3:0]  miss;

    int n_checks = 0;
    int n_fail   = 0;

    edf_selector #(
        .QUEUES         (4),
        .DEADLINE_WIDTH (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .pending    (pending),
        .period     (period),
        .miss_clear (miss_clear),
        .valid      (valid),
        .id         (id),
        .miss       (miss)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Drop all requests for two edges so every counter reloads from period.
    task automatic settle;
        pending = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_reset;
        reset = 1'b0; enable = 1'b0; pending = '0; period = '0; miss_clear = 1'b0;
        tick();
        tick();
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", valid); end
        n_checks++; if (id !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", id); end
        n_checks++; if (miss !== 4'b0000) begin n_fail++; $display("FAIL reset_miss: got %b want 0000", miss); end
        reset  = 1'b1;
        enable = 1'b1;
    endtask

    task automatic test_edf_order;
        period = {8'd40, 8'd30, 8'd20, 8'd10};
        settle();
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL edf_idle: valid got %0b want 0", valid); end
        pending = 4'b1111;
        tick();
        n_checks++; if ({valid, id} !== {1'b1, 2'd0}) begin n_fail++; $display("FAIL edf_g0: valid/id got %0b/%0d want 1/0", valid, id); end
        tick();
        n_checks++; if ({valid, id} !== {1'b1, 2'd1}) begin n_fail++; $display("FAIL edf_g1: valid/id got %0b/%0d want 1/1", valid, id); end
        tick();
        n_checks++; if ({valid, id} !== {1'b1, 2'd0}) begin n_fail++; $display("FAIL edf_g2: valid/id got %0b/%0d want 1/0", valid, id); end
        tick();
        n_checks++; if ({valid, id} !== {1'b1, 2'd1}) begin n_fail++; $display("FAIL edf_g3: valid/id got %0b/%0d want 1/1", valid, id); end
        n_checks++; if (miss !== 4'b0000) begin n_fail++; $display("FAIL edf_miss: got %b want 0000", miss); end
        settle();
    endtask

    task automatic test_tie_break;
        period = {4{8'd5}};
        settle();
        pending = 4'b0110;
        tick();
        n_checks++; if ({valid, id} !== {1'b1, 2'd1}) begin n_fail++; $display("FAIL tie_g0: valid/id got %0b/%0d want 1/1", valid, id); end
        tick();
        n_checks++; if ({valid, id} !== {1'b1, 2'd2}) begin n_fail++; $display("FAIL tie_g1: valid/id got %0b/%0d want 1/2", valid, id); end
        tick();
        n_checks++; if ({valid, id} !== {1'b1, 2'd1}) begin n_fail++; $display("FAIL tie_g2: valid/id got %0b/%0d want 1/1", valid, id); end
        settle();
    endtask

    task automatic test_miss;
        period = {8'd0, 8'd9, 8'd9, 8'd9};
        settle();
        pending = 4'b1000;
        tick();
        n_checks++; if (miss !== 4'b1000) begin n_fail++; $display("FAIL miss_set: got %b want 1000", miss); end
        n_checks++; if ({valid, id} !== {1'b1, 2'd3}) begin n_fail++; $display("FAIL miss_grant: valid/id got %0b/%0d want 1/3", valid, id); end
        pending = 4'b0000;
        tick();
        n_checks++; if (miss !== 4'b1000) begin n_fail++; $display("FAIL miss_hold1: got %b want 1000", miss); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL miss_novalid: got %0b want 0", valid); end
        tick();
        n_checks++; if (miss !== 4'b1000) begin n_fail++; $display("FAIL miss_hold2: got %b want 1000", miss); end
        miss_clear = 1'b1;
        tick();
        miss_clear = 1'b0;
        n_checks++; if (miss !== 4'b0000) begin n_fail++; $display("FAIL miss_clear: got %b want 0000", miss); end
        // Set and clear in the same cycle: the set must win.
        pending    = 4'b1000;
        miss_clear = 1'b1;
        tick();
        n_checks++; if (miss !== 4'b1000) begin n_fail++; $display("FAIL miss_set_wins: got %b want 1000", miss); end
        // Granted cycle does not set, so the still-asserted clear takes effect.
        tick();
        n_checks++; if (miss !== 4'b0000) begin n_fail++; $display("FAIL miss_granted_noset: got %b want 0000", miss); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL miss_masked: valid got %0b want 0", valid); end
        miss_clear = 1'b0;
        settle();
    endtask

    task automatic test_freeze;
        period = {8'd40, 8'd30, 8'd20, 8'd10};
        settle();
        pending = 4'b1111;
        tick();
        n_checks++; if ({valid, id} !== {1'b1, 2'd0}) begin n_fail++; $display("FAIL frz_pre0: valid/id got %0b/%0d want 1/0", valid, id); end
        tick();
        n_checks++; if ({valid, id} !== {1'b1, 2'd1}) begin n_fail++; $display("FAIL frz_pre1: valid/id got %0b/%0d want 1/1", valid, id); end
        enable = 1'b0;
        tick();
        n_checks++; if ({valid, id} !== {1'b0, 2'd1}) begin n_fail++; $display("FAIL frz_off0: valid/id got %0b/%0d want 0/1", valid, id); end
        tick();
        n_checks++; if ({valid, id} !== {1'b0, 2'd1}) begin n_fail++; $display("FAIL frz_off1: valid/id got %0b/%0d want 0/1", valid, id); end
        enable = 1'b1;
        tick();
        n_checks++; if ({valid, id} !== {1'b1, 2'd0}) begin n_fail++; $display("FAIL frz_resume0: valid/id got %0b/%0d want 1/0", valid, id); end
        tick();
        n_checks++; if ({valid, id} !== {1'b1, 2'd1}) begin n_fail++; $display("FAIL frz_resume1: valid/id got %0b/%0d want 1/1", valid, id); end
        n_checks++; if (miss !== 4'b0000) begin n_fail++; $display("FAIL frz_miss: got %b want 0000", miss); end
        settle();
    endtask

    task automatic test_back_to_back;
        period = {4{8'd7}};
        settle();
        pending = 4'b0100;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k % 2 == 0) begin
                n_checks++; if ({valid, id} !== {1'b1, 2'd2}) begin n_fail++; $display("FAIL b2b_grant%0d: valid/id got %0b/%0d want 1/2", k, valid, id); end
            end else begin
                n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap%0d: valid got %0b want 0", k, valid); end
            end
        end
        n_checks++; if (miss !== 4'b0000) begin n_fail++; $display("FAIL b2b_miss: got %b want 0000", miss); end
        settle();
    endtask

    task automatic test_reset_mid_grant;
        period = {8'd0, 8'd9, 8'd9, 8'd9};
        settle();
        pending = 4'b1000;
        tick();
        n_checks++; if ({valid, id, miss} !== {1'b1, 2'd3, 4'b1000}) begin n_fail++; $display("FAIL rst_pre: valid/id/miss got %0b/%0d/%b want 1/3/1000", valid, id, miss); end
        #1 reset = 1'b0;
        #1;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid: got %0b want 0", valid); end
        n_checks++; if (id !== 2'd0) begin n_fail++; $display("FAIL rst_async_id: got %0d want 0", id); end
        n_checks++; if (miss !== 4'b0000) begin n_fail++; $display("FAIL rst_async_miss: got %b want 0000", miss); end
        // Counters restart at all-ones, so all queues tie regardless of period.
        period  = {8'd10, 8'd20, 8'd30, 8'd40};
        pending = 4'b1111;
        #1 reset = 1'b1;
        #1;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_release: valid got %0b want 0", valid); end
        tick();
        n_checks++; if ({valid, id} !== {1'b1, 2'd0}) begin n_fail++; $display("FAIL rst_first: valid/id got %0b/%0d want 1/0", valid, id); end
        n_checks++; if (miss !== 4'b0000) begin n_fail++; $display("FAIL rst_first_miss: got %b want 0000", miss); end
        tick();
        n_checks++; if ({valid, id} !== {1'b1, 2'd1}) begin n_fail++; $display("FAIL rst_second: valid/id got %0b/%0d want 1/1", valid, id); end
        settle();
    endtask

    initial begin
        test_reset();
        test_edf_order();
        test_tie_break();
        test_miss();
        test_freeze();
        test_back_to_back();
        test_reset_mid_grant();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/edf_selector.md
EDF_SELECTOR -- requirements
Module: edf_selector

Interface
REQ-001 Parameter QUEUES, default 4: number of request queues; the dispatch stage fed by this block uses the same value for its output count.
REQ-002 Parameter DEADLINE_WIDTH, default 16: width of each per-queue deadline counter and period field.
REQ-003 clock  input  1: single clock; all state updates on its rising edge.
REQ-004 reset  input  1: asynchronous, active-low reset.
REQ-005 enable  input  1: 1 = scheduling active; 0 = scheduling frozen.
REQ-006 pending  input  QUEUES: bit i = 1 when queue i holds at least one request.
REQ-007 period  input  QUEUES*DEADLINE_WIDTH: relative deadline of queue i, at bits [i*DEADLINE_WIDTH +: DEADLINE_WIDTH]; unsigned cycles.
REQ-008 miss_clear  input  1: when 1, clears all sticky miss flags.
REQ-009 valid  output  1: registered grant strobe; drives the dispatch stage's valid input.
REQ-010 id  output  $clog2(QUEUES): registered index of the granted queue; meaningful only when valid = 1.
REQ-011 miss  output  QUEUES: sticky per-queue deadline-miss flags.

Function
REQ-012 The block SHALL hold one deadline counter d[i] per queue, DEADLINE_WIDTH bits, unsigned.
REQ-013 A queue is granted in cycle t when valid = 1 and id = i during cycle t.
REQ-014 Counter rules with enable = 1, in priority order:
  - queue granted in the cycle: d[i] <= period[i];
  - pending[i] = 0: d[i] <= period[i];
  - otherwise: d[i] <= d[i]-1, saturating at 0.
REQ-015 With enable = 0, all d[i] SHALL hold their value.
REQ-016 Candidates in cycle t: queues with pending[i] = 1 that are not granted in cycle t. The mask covers the one-cycle pop latency of the dispatch stage.
REQ-017 Selection SHALL pick the candidate with the smallest d[i]; ties SHALL go to the lowest index.
REQ-018 Selection SHALL be combinational on cycle-t state and registered: if enable = 1 and a candidate exists, valid = 1 and id = selection in cycle t+1; otherwise valid = 0 and id holds its previous value.
REQ-019 Latency from pending rising to first grant: exactly 1 cycle.
REQ-020 At most one grant per cycle; the same queue SHALL never be granted in two consecutive cycles.
REQ-021 With enable = 1, miss[i] SHALL set when pending[i] = 1, d[i] = 0 and queue i is not granted in the cycle.
REQ-022 miss[i] SHALL clear on miss_clear = 1; a set condition in the same cycle wins over the clear.
REQ-023 period[i] = 0 is legal: the queue is maximally urgent and misses whenever it is pending and not granted.
REQ-024 A change of period[i] SHALL take effect only at the next reload.

Reset
REQ-025 While reset = 0: valid = 0, id = 0, miss = 0, and all d[i] = all-ones, all asynchronously.
REQ-026 Reset asserted mid-grant SHALL drop valid immediately, without waiting for a clock edge.
REQ-027 The first grant after reset release SHALL come no earlier than one cycle after the first rising edge with reset = 1.

Verification
REQ-028 Reset: assert reset = 0 while valid = 1 -> valid = 0, id = 0, miss = 4'b0000 with no clock edge.
REQ-029 EDF order: QUEUES = 4, DEADLINE_WIDTH = 8, periods {10,20,30,40}, pending 0 then 4'b1111 held -> ids 0, 1, 0, 1 in four consecutive cycles, starting one cycle after pending rises.
REQ-030 Tie-break: all periods 5, pending = 4'b0110 held -> id = 1 then id = 2 on consecutive cycles.
REQ-031 Miss: period[3] = 0, pending = 4'b1000 for one cycle then 0 -> miss = 4'b1000 one cycle later and held; one-cycle miss_clear pulse -> miss = 0 the next cycle.
REQ-032 Freeze: enable = 0 during alternating grants -> valid = 0 from the next cycle, d[] unchanged; enable = 1 again -> grants resume with the same order.
REQ-033 Double-grant check: only pending[2] held at 1 with the pop delayed -> grants to queue 2 occur at most every other cycle; valid never stays high with id = 2 for two consecutive cycles.
